// File: rtl/dht11_pkg.sv
// dht11_pkg: shared definitions for the DHT11 controller.
//   - state_e     : FSM states; the enum value is also the 4-bit led code
//   - frame byte indices, frame/counter widths, STOP hold time
//   - us_div()    : system-clock cycles per 1 us tick
//   - frame_byte(), checksum_ok() : frame helpers
package dht11_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_START       = 4'd1,
        ST_RELEASE     = 4'd2,
        ST_WAIT_RESP   = 4'd3,
        ST_SYNC_L      = 4'd4,
        ST_SYNC_H      = 4'd5,
        ST_DATA_SYNC   = 4'd6,
        ST_DATA_DETECT = 4'd7,
        ST_DONE        = 4'd8,
        ST_STOP        = 4'd9
    } state_e;

    localparam int unsigned FRAME_W   = 40;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned US_CNT_W  = 20;
    localparam int unsigned BIT_CNT_W = 6;
    localparam int unsigned STOP_US   = 50;

    // Byte positions within the 40-bit frame (byte 4 = bits 39:32)
    localparam int unsigned BYTE_RH_INT = 4;
    localparam int unsigned BYTE_RH_DEC = 3;
    localparam int unsigned BYTE_T_INT  = 2;
    localparam int unsigned BYTE_T_DEC  = 1;
    localparam int unsigned BYTE_CSUM   = 0;

    // Cycles per microsecond; clamped to 1 for clocks below 1 MHz
    function automatic int unsigned us_div(input int unsigned clk_hz);
        return (clk_hz < 1_000_000) ? 1 : clk_hz / 1_000_000;
    endfunction

    function automatic logic [BYTE_W-1:0] frame_byte(input logic [FRAME_W-1:0] f,
                                                     input int unsigned idx);
        return f[idx*BYTE_W +: BYTE_W];
    endfunction

    // 8-bit wrap-around sum of the four data bytes must equal the checksum byte
    function automatic logic checksum_ok(input logic [FRAME_W-1:0] f);
        logic [BYTE_W-1:0] sum;
        sum = frame_byte(f, BYTE_RH_INT) + frame_byte(f, BYTE_RH_DEC)
            + frame_byte(f, BYTE_T_INT)  + frame_byte(f, BYTE_T_DEC);
        return sum == frame_byte(f, BYTE_CSUM);
    endfunction

endpackage

// File: rtl/dht11_controller_tick_gen.sv
// dht11_tick_gen: free-running 1 us tick generator.
//   clk, rst : clock, async active-high reset
//   tick_o   : one-cycle pulse every us_div(CLK_FREQ_HZ) cycles
module dht11_tick_gen
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned DIV   = us_div(CLK_FREQ_HZ);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DIV_W-1:0] cnt_q;
    logic             tick_q;

    // Modulo-DIV counter; tick marks its wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == DIV_W'(DIV - 1)) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + DIV_W'(1);
            tick_q <= 1'b0;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/dht11_controller.sv
// dht11_controller: host-side DHT11 single-wire sensor controller.
// Issues the start pulse, validates the sensor response, decodes 40 bits
// by high-pulse width and reports humidity/temperature integer bytes.
//   clk, rst    : system clock, async active-high reset
//   start       : measurement request, honoured in IDLE only
//   rhdata      : humidity integer byte (frame[39:32])
//   t_data      : temperature integer byte (frame[23:16])
//   dht11_done  : one-cycle pulse at the end of every transaction
//   dht11_valid : checksum result of the last transaction (0 on error)
//   led         : current FSM state code
//   dht11_io    : open-drain sensor line (driven only in START/RELEASE)
// Build option: define DHT11_IO_SYNC_EN to add a 2-flop synchroniser on
// the sampled line ahead of edge detection.
module dht11_controller
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
    parameter int unsigned START_LOW_US     = 18000,
    parameter int unsigned RELEASE_US       = 20,
    parameter int unsigned SYNC_MIN_US      = 60,
    parameter int unsigned BIT_THRESHOLD_US = 40,
    parameter int unsigned TIMEOUT_US       = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [BYTE_W-1:0]   rhdata,
    output logic [BYTE_W-1:0]   t_data,
    output logic                dht11_done,
    output logic                dht11_valid,
    output logic [3:0]          led,
    inout  wire                 dht11_io
);

    state_e                 state_q, state_d;
    logic [US_CNT_W-1:0]    us_cnt_q, us_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]     frame_q, frame_d;
    logic [BYTE_W-1:0]      rh_q, rh_d;
    logic [BYTE_W-1:0]      t_q, t_d;
    logic                   done_q, done_d;
    logic                   valid_q, valid_d;
    logic                   oe_q, oe_d;
    logic                   drv_q, drv_d;
    logic                   io_s_q, io_p_q;
    logic                   tick_c, rise_c, fall_c, timeout_c, err_c;

    dht11_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick_c)
    );

    // Line sampling; idle level is high so reset values avoid a false edge
`ifdef DHT11_IO_SYNC_EN
    logic [1:0] io_sync_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_sync_q <= 2'b11;
            io_s_q    <= 1'b1;
            io_p_q    <= 1'b1;
        end else begin
            io_sync_q <= {io_sync_q[0], dht11_io};
            io_s_q    <= io_sync_q[1];
            io_p_q    <= io_s_q;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_s_q <= 1'b1;
            io_p_q <= 1'b1;
        end else begin
            io_s_q <= dht11_io;
            io_p_q <= io_s_q;
        end
    end
`endif

    assign rise_c    = ~io_p_q &  io_s_q;
    assign fall_c    =  io_p_q & ~io_s_q;
    assign timeout_c = (us_cnt_q >= US_CNT_W'(TIMEOUT_US));

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            us_cnt_q  <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            rh_q      <= '0;
            t_q       <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            oe_q      <= 1'b0;
            drv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            us_cnt_q  <= us_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            rh_q      <= rh_d;
            t_q       <= t_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            oe_q      <= oe_d;
            drv_q     <= drv_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        rh_d      = rh_q;
        t_d       = t_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        err_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    valid_d = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick_c && us_cnt_q == US_CNT_W'(START_LOW_US - 1)) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (tick_c && us_cnt_q == US_CNT_W'(RELEASE_US - 1)) state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (fall_c)         state_d = ST_SYNC_L;
                else if (timeout_c) err_c   = 1'b1;
            end
            ST_SYNC_L: begin
                // Too-short response low is treated as noise, not a sensor
                if (rise_c) begin
                    if (us_cnt_q >= US_CNT_W'(SYNC_MIN_US)) state_d = ST_SYNC_H;
                    else                                    err_c   = 1'b1;
                end else if (timeout_c) begin
                    err_c = 1'b1;
                end
            end
            ST_SYNC_H: begin
                if (fall_c) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA_SYNC;
                end else if (timeout_c) begin
                    err_c = 1'b1;
                end
            end
            ST_DATA_SYNC: begin
                if (rise_c)         state_d = ST_DATA_DETECT;
                else if (timeout_c) err_c   = 1'b1;
            end
            ST_DATA_DETECT: begin
                // High width since the rise decides the bit value
                if (fall_c) begin
                    frame_d   = {frame_q[FRAME_W-2:0], (us_cnt_q > US_CNT_W'(BIT_THRESHOLD_US))};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    state_d   = (bit_cnt_q == BIT_CNT_W'(FRAME_W - 1)) ? ST_DONE : ST_DATA_SYNC;
                end else if (timeout_c) begin
                    err_c = 1'b1;
                end
            end
            ST_DONE: begin
                rh_d    = frame_byte(frame_q, BYTE_RH_INT);
                t_d     = frame_byte(frame_q, BYTE_T_INT);
                valid_d = checksum_ok(frame_q);
                done_d  = 1'b1;
                state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick_c && us_cnt_q == US_CNT_W'(STOP_US - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any protocol error ends the transaction with stale data kept
        if (err_c) begin
            done_d  = 1'b1;
            valid_d = 1'b0;
            state_d = ST_STOP;
        end

        if (state_d != state_q) us_cnt_d = '0;
        else if (tick_c)        us_cnt_d = us_cnt_q + US_CNT_W'(1);
        else                    us_cnt_d = us_cnt_q;

        // Drive controls follow the next state so the pad tracks state_q
        oe_d  = (state_d == ST_START) || (state_d == ST_RELEASE);
        drv_d = (state_d == ST_RELEASE);
    end

    assign dht11_io    = oe_q ? drv_q : 1'bz;
    assign rhdata      = rh_q;
    assign t_data      = t_q;
    assign dht11_done  = done_q;
    assign dht11_valid = valid_q;
    assign led         = 4'(state_q);

endmodule

// File: tb/tb_dht11_controller.sv
// Testbench for dht11_controller: sensor model on a pulled-up line,
// table of transactions with a done-triggered scoreboard, plus reset cases.
// Runs with a 2 MHz clock (2 cycles/us) and a shortened 300 us start pulse.
module tb_dht11_controller;

    localparam int unsigned CLK_HZ   = 2_000_000;
    localparam int unsigned CPU      = 2;     // cycles per us
    localparam int unsigned START_US = 300;
    localparam int unsigned REL_US   = 20;
    localparam int unsigned TO_US    = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] rhdata, t_data;
    logic       dht11_done, dht11_valid;
    logic [3:0] led;
    logic       sens_low;
    wire        dht11_io;

    pullup (dht11_io);
    assign dht11_io = sens_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht11_controller #(
        .CLK_FREQ_HZ      (CLK_HZ),
        .START_LOW_US     (START_US),
        .RELEASE_US       (REL_US),
        .SYNC_MIN_US      (60),
        .BIT_THRESHOLD_US (40),
        .TIMEOUT_US       (TO_US)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rhdata      (rhdata),
        .t_data      (t_data),
        .dht11_done  (dht11_done),
        .dht11_valid (dht11_valid),
        .led         (led),
        .dht11_io    (dht11_io)
    );

    typedef struct {
        logic [39:0] frame;
        int unsigned resp_low_us;
        bit          respond;
        logic [7:0]  rh;
        logic [7:0]  t;
        bit          valid;
    } vec_t;

    typedef struct {
        logic [7:0] rh;
        logic [7:0] t;
        bit         valid;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    logic done_prev = 1'b0;
    vec_t vecs[6];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int unsigned act,
                           input int unsigned lo, input int unsigned hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard: every done pulse pops one expectation
    always @(negedge clk) begin
        if (dht11_done) begin
            done_cnt++;
            chk("done_pulse_width", 32'(done_prev), 0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard");
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_rhdata", rhdata, mon_e.rh);
                chk("sb_t_data", t_data, mon_e.t);
                chk("sb_valid", 32'(dht11_valid), 32'(mon_e.valid));
            end
        end
        done_prev = dht11_done;
    end

    task automatic us_delay(input int unsigned n);
        repeat (n * CPU) @(negedge clk);
    endtask

    task automatic wait_led(input logic [3:0] v, input int max_cyc, input string name);
        int n = 0;
        while (led != v && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk(name, led, v);
    endtask

    task automatic sensor_frame(input logic [39:0] f, input int unsigned resp_low);
        us_delay(20);
        sens_low = 1'b1; us_delay(resp_low);
        sens_low = 1'b0; us_delay(80);
        for (int i = 39; i >= 0; i--) begin
            sens_low = 1'b1; us_delay(50);
            sens_low = 1'b0; us_delay(f[i] ? 68 : 29);
        end
        sens_low = 1'b1; us_delay(50);
        sens_low = 1'b0;
    endtask

    // Start request plus checks of the host start/release pulse shape
    task automatic host_phase();
        int n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (dht11_io !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        chk("start_line_low", 32'(dht11_io), 0);
        chk("led_start", led, 1);
        n = 0;
        while (dht11_io === 1'b0 && n < int'(START_US * CPU + 100)) begin @(negedge clk); n++; end
        chk_rng("start_low_cycles", n, (START_US - 1) * CPU, (START_US + 1) * CPU);
        chk("led_release", led, 2);
        chk("release_line_high", 32'(dht11_io), 1);
        n = 0;
        while (led == 4'd2 && n < int'(REL_US * CPU + 50)) begin @(negedge clk); n++; end
        chk_rng("release_cycles", n, (REL_US - 1) * CPU, (REL_US + 1) * CPU);
        chk("led_wait_resp", led, 3);
        chk("line_released", 32'(dht11_io), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int   d0;
        int   n;
        exp_t e;
        wait_led(4'd0, 400, "idle_before_start");
        e.rh = v.rh; e.t = v.t; e.valid = v.valid;
        sb_q.push_back(e);
        d0 = done_cnt;
        host_phase();
        if (v.respond) begin
            sensor_frame(v.frame, v.resp_low_us);
        end else begin
            n = 0;
            while (done_cnt == d0 && n < int'((TO_US + 100) * CPU)) begin @(negedge clk); n++; end
            chk_rng("timeout_cycles", n, (TO_US - 2) * CPU, (TO_US + 3) * CPU);
        end
        n = 0;
        while (done_cnt == d0 && n < int'((TO_US + 100) * CPU)) begin @(negedge clk); n++; end
        chk("done_count", done_cnt - d0, 1);
        wait_led(4'd0, 400, "idle_after_txn");
        chk("hold_rhdata", rhdata, v.rh);
        chk("hold_t_data", t_data, v.t);
        chk("hold_valid", 32'(dht11_valid), 32'(v.valid));
    endtask

    initial begin
        #(950_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; sens_low = 1'b0;
        //            frame              resp respond rh     t      valid
        vecs[0] = '{40'hAA0FC6007F, 80, 1'b1, 8'hAA, 8'hC6, 1'b1};
        vecs[1] = '{40'hAA0FC6007E, 80, 1'b1, 8'hAA, 8'hC6, 1'b0};
        vecs[2] = '{40'h1234567814, 80, 1'b1, 8'h12, 8'h56, 1'b1};
        vecs[3] = '{40'h3C00190055, 20, 1'b1, 8'h12, 8'h56, 1'b0};  // short response low
        vecs[4] = '{40'h0000000000, 0,  1'b0, 8'h12, 8'h56, 1'b0};  // no sensor
        vecs[5] = '{40'hFFFFFFFFFC, 80, 1'b1, 8'hFF, 8'hFF, 1'b1};

        repeat (5) @(negedge clk);
        chk("rst_led", led, 0);
        chk("rst_rhdata", rhdata, 0);
        chk("rst_t_data", t_data, 0);
        chk("rst_done", 32'(dht11_done), 0);
        chk("rst_valid", 32'(dht11_valid), 0);
        chk("rst_line", 32'(dht11_io), 1);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_led", led, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset while decoding data bits
        wait_led(4'd0, 400, "idle_before_abort");
        host_phase();
        us_delay(20);
        sens_low = 1'b1; us_delay(80);
        sens_low = 1'b0; us_delay(80);
        for (int i = 0; i < 5; i++) begin
            sens_low = 1'b1; us_delay(50);
            sens_low = 1'b0; us_delay(29);
        end
        sens_low = 1'b1; us_delay(50);
        sens_low = 1'b0; us_delay(10);
        chk("abort_led_detect", led, 7);
        #1 rst = 1'b1;
        #1;
        chk("abort_led", led, 0);
        chk("abort_rhdata", rhdata, 0);
        chk("abort_t_data", t_data, 0);
        chk("abort_valid", 32'(dht11_valid), 0);
        chk("abort_done", 32'(dht11_done), 0);
        chk("abort_line", 32'(dht11_io), 1);
        @(negedge clk) rst = 1'b0;

        // Reset while driving the start pulse releases the line at once
        repeat (5) @(negedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pulse_line_low", 32'(dht11_io), 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_pulse_line", 32'(dht11_io), 1);
        chk("rst_pulse_led", led, 0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);

        run_vec(vecs[0]);

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
